// File: rtl/seg_display.sv
// Bus-mapped eight-digit common-anode seven-segment scanner with data/control readback.
// Optional leading-zero blanking is compiled in when SEG_DISPLAY_LZB_EN is defined.
module seg_display #(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [31:0] DATA_ADDR = 32'h0000_7f38,
    parameter logic [31:0] CTRL_ADDR = 32'h0000_7f3c
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ADD_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    output logic [31:0] DAT_O,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n
);

    logic [31:0] data_r;
    logic [15:0] ctrl_r;
    logic [15:0] cnt_r;
    logic [2:0]  idx_r;

    logic        sel_data;
    logic        sel_ctrl;
    logic [7:0]  en_mask;
    logic [7:0]  dp_mask;
    logic [3:0]  nibble;
    logic        digit_on;
    logic [6:0]  hex_seg;

    assign sel_data = (ADD_I == DATA_ADDR);
    assign sel_ctrl = (ADD_I == CTRL_ADDR);
    assign en_mask  = ctrl_r[7:0];
    assign dp_mask  = ctrl_r[15:8];
    assign nibble   = data_r[{idx_r, 2'b00} +: 4];

    // Active-low g..a patterns for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        case (value)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign hex_seg = hex_to_seg(nibble);

`ifdef SEG_DISPLAY_LZB_EN
    // A digit above 0 goes dark when it and every more-significant nibble are zero.
    logic lz_blank;
    assign lz_blank = (idx_r != 3'd0) && ((data_r >> {idx_r, 2'b00}) == 32'd0);
    assign digit_on = en_mask[idx_r] && !lz_blank;
`else
    assign digit_on = en_mask[idx_r];
`endif

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        DAT_O = 32'd0;
        if (sel_data)
            DAT_O = data_r;
        else if (sel_ctrl)
            DAT_O = {16'd0, ctrl_r};
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= 32'd0;
            ctrl_r <= 16'h00FF;
        end else if (WE_I) begin
            if (sel_data)
                data_r <= DAT_I;
            else if (sel_ctrl)
                ctrl_r <= DAT_I[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 16'd0;
            idx_r <= 3'd0;
        end else if (cnt_r == SCAN_DIV - 16'd1) begin
            cnt_r <= 16'd0;
            idx_r <= idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Outputs are registered from the current scan slot, so they trail idx_r by one edge.
    always_ff @(posedge clk) begin
        if (reset || !digit_on) begin
            an_n  <= 8'hFF;
            seg_n <= 8'hFF;
        end else begin
            an_n  <= ~(8'd1 << idx_r);
            seg_n <= {~dp_mask[idx_r], hex_seg};
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display with SCAN_DIV=4; a cycle counter tracks which digit is on screen.
module tb_seg_display;

    localparam logic [31:0] DATA_ADDR = 32'h0000_7f38;
    localparam logic [31:0] CTRL_ADDR = 32'h0000_7f3c;
    localparam logic [31:0] BAD_ADDR  = 32'h0000_7f40;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ADD_I;
    logic [31:0] DAT_I;
    logic        WE_I;
    logic [31:0] DAT_O;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;

    int checks = 0;
    int fails  = 0;
    int edges  = 0;

    logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_1234 [8] = '{8'h8E, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    seg_display #(
        .SCAN_DIV (16'd4),
        .DATA_ADDR(DATA_ADDR),
        .CTRL_ADDR(CTRL_ADDR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ADD_I(ADD_I),
        .DAT_I(DAT_I),
        .WE_I (WE_I),
        .DAT_O(DAT_O),
        .seg_n(seg_n),
        .an_n (an_n)
    );

    always #5 clk = ~clk;

    // Edges since reset: after edge k the screen shows digit ((k-1)/4)%8.
    always @(posedge clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic goto_digit(input int d);
        int n = 0;
        repeat (2) @(negedge clk);
        while (!((edges >= 1) && ((((edges - 1) / 4) % 8) == d)) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("goto_digit_timeout", 32'd0, 32'd1);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] exp_old, input logic [31:0] exp_new);
        @(negedge clk);
        ADD_I = addr;
        DAT_I = data;
        WE_I  = 1'b1;
        #1 check("read_in_write_cycle", DAT_O, exp_old);
        @(negedge clk);
        WE_I = 1'b0;
        #1 check("read_after_write", DAT_O, exp_new);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ADD_I = 32'd0;
        DAT_I = 32'd0;
        WE_I  = 1'b0;

        // Writes during reset must be dropped.
        @(negedge clk);
        ADD_I = DATA_ADDR;
        DAT_I = 32'hDEAD_BEEF;
        WE_I  = 1'b1;
        repeat (2) @(negedge clk);
        WE_I = 1'b0;
        check("reset_an", {24'd0, an_n}, 32'hFF);
        check("reset_seg", {24'd0, seg_n}, 32'hFF);
        check("reset_data", DAT_O, 32'd0);
        ADD_I = CTRL_ADDR;
        #1 check("reset_ctrl", DAT_O, 32'h0000_00FF);
        ADD_I = 32'd0;
        #1 check("idle_addr_read", DAT_O, 32'd0);

        reset = 1'b0;
        #1 check("release_an", {24'd0, an_n}, 32'hFF);
        check("release_seg", {24'd0, seg_n}, 32'hFF);

        // Full scan plus wrap: each digit held 4 cycles, all showing 0 with dp off.
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            check("scan_an", {24'd0, an_n}, {24'd0, an_tab[((k - 1) / 4) % 8]});
            check("scan_seg", {24'd0, seg_n}, 32'hC0);
        end

        bus_write(DATA_ADDR, 32'h1234_ABCF, 32'd0, 32'h1234_ABCF);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d);
            check("data_an", {24'd0, an_n}, {24'd0, an_tab[d]});
            check("data_seg", {24'd0, seg_n}, {24'd0, seg_1234[d]});
        end

        bus_write(BAD_ADDR, 32'hFFFF_FFFF, 32'd0, 32'd0);
        ADD_I = DATA_ADDR;
        #1 check("bad_write_data", DAT_O, 32'h1234_ABCF);
        ADD_I = CTRL_ADDR;
        #1 check("bad_write_ctrl", DAT_O, 32'h0000_00FF);

        bus_write(CTRL_ADDR, 32'h0001_0305, 32'h0000_00FF, 32'h0000_0305);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d);
            case (d)
                0: begin
                    check("ctrl_an0", {24'd0, an_n}, 32'hFE);
                    check("ctrl_seg0", {24'd0, seg_n}, 32'h0E);
                end
                2: begin
                    check("ctrl_an2", {24'd0, an_n}, 32'hFB);
                    check("ctrl_seg2", {24'd0, seg_n}, 32'h83);
                end
                default: begin
                    check("ctrl_an_off", {24'd0, an_n}, 32'hFF);
                    check("ctrl_seg_off", {24'd0, seg_n}, 32'hFF);
                end
            endcase
        end

        // Reset while idx_r=5, cnt_r=2 (22 edges into a frame).
        n = 0;
        while (((edges % 32) != 22) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("midscan_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ADD_I = DATA_ADDR;
        #1 check("midscan_an", {24'd0, an_n}, 32'hFF);
        check("midscan_seg", {24'd0, seg_n}, 32'hFF);
        check("midscan_data", DAT_O, 32'd0);
        ADD_I = CTRL_ADDR;
        #1 check("midscan_ctrl", DAT_O, 32'h0000_00FF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("restart_an", {24'd0, an_n}, (k <= 4) ? 32'hFE : 32'hFD);
            check("restart_seg", {24'd0, seg_n}, 32'hC0);
        end

        bus_write(DATA_ADDR, 32'h0000_00A0, 32'd0, 32'h0000_00A0);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d);
`ifdef SEG_DISPLAY_LZB_EN
            check("lzb_an", {24'd0, an_n}, (d < 2) ? {24'd0, an_tab[d]} : 32'hFF);
            check("lzb_seg", {24'd0, seg_n}, (d == 1) ? 32'h88 : ((d == 0) ? 32'hC0 : 32'hFF));
`else
            check("lz_an", {24'd0, an_n}, {24'd0, an_tab[d]});
            check("lz_seg", {24'd0, seg_n}, (d == 1) ? 32'h88 : 32'hC0);
`endif
        end

        bus_write(DATA_ADDR, 32'd0, 32'h0000_00A0, 32'd0);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d);
`ifdef SEG_DISPLAY_LZB_EN
            check("zero_an", {24'd0, an_n}, (d == 0) ? 32'hFE : 32'hFF);
            check("zero_seg", {24'd0, seg_n}, (d == 0) ? 32'hC0 : 32'hFF);
`else
            check("zero_an", {24'd0, an_n}, {24'd0, an_tab[d]});
            check("zero_seg", {24'd0, seg_n}, 32'hC0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_display.md
Name: seg_display

Overview:
- Memory-mapped output peripheral on the CPU bridge; the output-side counterpart of the user-key input device.
- The CPU writes a 32-bit value: 8 hex nibbles.
- The block time-multiplexes eight common-anode seven-segment digits, one digit per scan slot.
- Readback of both registers is provided through DAT_O.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles each digit stays lit; legal range 2..65535.
- DATA_ADDR, 32'h0000_7f38, bus address of the display data register.
- CTRL_ADDR, 32'h0000_7f3c, bus address of the control register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ADD_I  input  32  bus address.
- DAT_I  input  32  bus write data.
- WE_I  input  1  bus write enable.
- DAT_O  output  32  bus read data.
- seg_n  output  8  segment drive, active low: [0]=a .. [6]=g, [7]=dp.
- an_n  output  8  digit select, active low: [i] = digit i; digit 0 is rightmost, showing nibble [3:0].

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Registers:
  - data_r[31:0]: reset 0.
  - ctrl_r[15:0]: [7:0] digit enable mask, [15:8] decimal-point mask; reset 16'h00FF.
- Write path:
  - WE_I=1 and ADD_I==DATA_ADDR: data_r <= DAT_I at the next edge.
  - WE_I=1 and ADD_I==CTRL_ADDR: ctrl_r <= DAT_I[15:0] at the next edge.
  - Any other address is ignored. Writes during reset are ignored.
- Read path (combinational, no wait states):
  - DAT_O = data_r when ADD_I==DATA_ADDR.
  - DAT_O = {16'b0, ctrl_r} when ADD_I==CTRL_ADDR.
  - Otherwise DAT_O = 0.
  - A same-cycle write is not visible on DAT_O until the following cycle.
- Scan counter:
  - cnt_r is 16 bits, idx_r is 3 bits; both reset to 0.
  - Each cycle: if cnt_r==SCAN_DIV-1, then cnt_r<=0 and idx_r<=idx_r+1, wrapping 7->0. Otherwise cnt_r<=cnt_r+1.
  - The scan runs continuously and is unaffected by bus writes.
- Output stage (registered):
  - Each edge, the outputs are computed from the current idx_r, data_r and ctrl_r.
  - an_n <= ~(8'b1 << idx_r) if ctrl_r[idx_r]=1, else 8'hFF (digit off).
  - seg_n[6:0] <= hex pattern of nibble data_r[4*idx_r+3 : 4*idx_r].
  - seg_n[7] <= ~ctrl_r[8+idx_r].
  - Disabled digit: an_n=8'hFF and seg_n=8'hFF.
- Latency:
  - A new idx_r appears on an_n one cycle after the idx_r change.
  - A register write appears on seg_n/an_n two edges after the write cycle, i.e. the register updates, then the output register updates.
- Reset values: seg_n=8'hFF and an_n=8'hFF during and in the cycle after reset; DAT_O follows its combinational rule.
- Reset mid-scan: cnt_r, idx_r and the registers return to their reset values on the same edge; no partial digit is retained.
- Hex patterns (seg_n[6:0], active low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Optional Feature:
- Macro: SEG_DISPLAY_LZB_EN (leading-zero blanking).
- Defined:
  - A digit i>0 is blanked (an_n=8'hFF, seg_n=8'hFF) when data_r[31:4*i]==0.
  - Digit 0 is never blanked by this rule.
  - The enable mask still applies on top of this rule.
- Undefined: all enabled digits show their nibble, including leading zeros.

Test Plan:
- SCAN_DIV=4. Reset, then release. Expected: an_n=FF and seg_n=FF on the first edge after release. The sequence an_n=FE,FD,FB,F7,EF,DF,BF,7F follows, each held for 4 cycles, then wraps to FE. seg_n=C0 on every digit (0 with dp off).
- Write DATA_ADDR=32'h1234_ABCF. Expected: digit0 seg_n=8E, digit1 C6, digit2 83, digit3 88, digit4 99, digit5 B0, digit6 A4, digit7 F9.
- Read DATA_ADDR in the write cycle. Expected: old value. Read DATA_ADDR the next cycle: 1234ABCF. Read 32'h7f40: 0. Write to 32'h7f40: no register changes.
- Write CTRL_ADDR=32'h0001_0305. Expected: digits 0 and 2 lit, all others an_n=FF/seg_n=FF. Digit0 has seg_n[7]=0. CTRL readback = 32'h0000_0305.
- Assert reset for 1 cycle while idx_r=5 and cnt_r=2. Expected: next cycle cnt_r=0, idx_r=0, data_r=0, ctrl_r=00FF, outputs FF.
- With SEG_DISPLAY_LZB_EN defined, write data=32'h0000_00A0. Expected: digit0 shows 0 (C0), digit1 shows A (88), digits 2-7 blanked. With data=0, only digit0 is lit, showing 0.
